// File: rtl/regbank_seq.sv
// Register-bank sequencer: accepts NOP/LOAD/MOVE/ALU instructions and drives bank and ALU controls.
// Optional ALU watchdog enabled by defining REGBANK_SEQ_TIMEOUT_EN.
module regbank_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [19:0] instr,
    input  logic [63:0] ld_data,
    output logic        regwen,
    output logic [3:0]  selwreg,
    output logic [1:0]  endwreg,
    output logic [3:0]  seloutA,
    output logic [3:0]  seloutB,
    output logic        cnstA,
    output logic        cnstB,
    output logic        enrregA,
    output logic        enrregB,
    output logic [63:0] wdata,
    input  logic [63:0] bank_outA,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    input  logic        alu_done,
    input  logic [63:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    typedef enum logic [2:0] {StIdle, StRead, StIssue, StWait, StWrite} state_e;

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpLoad = 2'b01;
    localparam logic [1:0] OpAlu  = 2'b10;
    localparam logic [1:0] OpMove = 2'b11;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e      state;
    logic [19:0] instr_q;
    logic [63:0] data_q;

    assign instr_ready = (state == StIdle);
    assign busy        = (state != StIdle);
    // MOVE forwards the bank's registered output straight through during its write cycle.
    assign wdata = (state == StWrite && instr_q[19:18] == OpMove) ? bank_outA : data_q;

`ifdef REGBANK_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;
`else
    logic unused_cfg;
    assign unused_cfg  = ^TimeoutCnt;
    assign err_timeout = 1'b0;
`endif

    logic unused_instr;
    assign unused_instr = ^instr_q[17:2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            instr_q   <= '0;
            data_q    <= '0;
            regwen    <= 1'b0;
            selwreg   <= '0;
            endwreg   <= '0;
            seloutA   <= '0;
            seloutB   <= '0;
            cnstA     <= 1'b0;
            cnstB     <= 1'b0;
            enrregA   <= 1'b0;
            enrregB   <= 1'b0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            done      <= 1'b0;
`ifdef REGBANK_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            regwen    <= 1'b0;
            enrregA   <= 1'b0;
            enrregB   <= 1'b0;
            alu_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        data_q  <= ld_data;
                        unique case (instr[19:18])
                            OpNop: done <= 1'b1;
                            OpLoad: begin
                                state   <= StWrite;
                                regwen  <= 1'b1;
                                done    <= 1'b1;
                                selwreg <= instr[17:14];
                                endwreg <= instr[3:2];
                            end
                            OpMove: begin
                                state   <= StRead;
                                enrregA <= 1'b1;
                                seloutA <= instr[13:10];
                                cnstA   <= instr[5];
                                selwreg <= instr[17:14];
                                endwreg <= instr[3:2];
                            end
                            OpAlu: begin
                                state   <= StRead;
                                enrregA <= 1'b1;
                                enrregB <= 1'b1;
                                seloutA <= instr[13:10];
                                seloutB <= instr[9:6];
                                cnstA   <= instr[5];
                                cnstB   <= instr[4];
                                selwreg <= instr[17:14];
                                endwreg <= instr[3:2];
                            end
                        endcase
                    end
                end
                StRead: begin
                    if (instr_q[19:18] == OpAlu) begin
                        state     <= StIssue;
                        alu_start <= 1'b1;
                        alu_op    <= instr_q[1:0];
                    end else begin
                        state  <= StWrite;
                        regwen <= 1'b1;
                        done   <= 1'b1;
                    end
                end
                StIssue: begin
                    state <= StWait;
`ifdef REGBANK_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                StWait: begin
                    if (alu_done) begin
                        data_q <= alu_result;
                        state  <= StWrite;
                        regwen <= 1'b1;
                        done   <= 1'b1;
                    end
`ifdef REGBANK_SEQ_TIMEOUT_EN
                    // wait_cnt counts completed WAIT cycles; this one is the TIMEOUT-th.
                    else if (wait_cnt == TimeoutCnt - 8'd1) begin
                        state       <= StIdle;
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                StWrite: begin
                    state <= StIdle;
                    if (instr_q[19:18] == OpMove) begin
                        data_q <= bank_outA;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_seq.sv
// Directed self-checking bench for regbank_seq; exercises the watchdog path when
// REGBANK_SEQ_TIMEOUT_EN is defined.
module tb_regbank_seq;

`ifdef REGBANK_SEQ_TIMEOUT_EN
    localparam int AluDelay = 2;
`else
    localparam int AluDelay = 5;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [19:0] instr;
    logic [63:0] ld_data;
    logic        regwen;
    logic [3:0]  selwreg;
    logic [1:0]  endwreg;
    logic [3:0]  seloutA;
    logic [3:0]  seloutB;
    logic        cnstA;
    logic        cnstB;
    logic        enrregA;
    logic        enrregB;
    logic [63:0] wdata;
    logic [63:0] bank_outA;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic        alu_done;
    logic [63:0] alu_result;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    regbank_seq #(.TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .ld_data    (ld_data),
        .regwen     (regwen),
        .selwreg    (selwreg),
        .endwreg    (endwreg),
        .seloutA    (seloutA),
        .seloutB    (seloutB),
        .cnstA      (cnstA),
        .cnstB      (cnstB),
        .enrregA    (enrregA),
        .enrregB    (enrregB),
        .wdata      (wdata),
        .bank_outA  (bank_outA),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout)
    );

    function automatic logic [19:0] mk(input logic [1:0] opc, input logic [3:0] dst,
                                       input logic [3:0] sa, input logic [3:0] sb,
                                       input logic ca, input logic cb,
                                       input logic [1:0] ew, input logic [1:0] aop);
        return {opc, dst, sa, sb, ca, cb, ew, aop};
    endfunction

    // Presents one instruction for a single edge; returns at the negedge of cycle 1.
    task automatic issue(input logic [19:0] i, input logic [63:0] d);
        instr_valid = 1'b1;
        instr       = i;
        ld_data     = d;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        instr       = '0;
        ld_data     = '0;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        ld_data     = '0;
        alu_done    = 1'b0;
        alu_result  = '0;
        bank_outA   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({regwen, enrregA, enrregB, cnstA, cnstB, alu_start, done, err_timeout, busy}
            !== 9'b0) begin
            $display("FAIL reset_ctrl: got %b expected %b", {regwen, enrregA, enrregB, cnstA,
                     cnstB, alu_start, done, err_timeout, busy}, 9'b0);
            n_fail++;
        end
        n_checks++;
        if ({selwreg, endwreg, seloutA, seloutB, alu_op} !== 16'h0000) begin
            $display("FAIL reset_sel: got %h expected %h",
                     {selwreg, endwreg, seloutA, seloutB, alu_op}, 16'h0000);
            n_fail++;
        end
        n_checks++;
        if (wdata !== 64'h0) begin
            $display("FAIL reset_wdata: got %h expected %h", wdata, 64'h0);
            n_fail++;
        end
        n_checks++;
        if (instr_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b expected 1", instr_ready);
            n_fail++;
        end
    endtask

    task automatic test_nop;
        issue(mk(2'b00, 4'd9, 4'd1, 4'd2, 1'b1, 1'b1, 2'b10, 2'b11), 64'h55);
        n_checks++;
        if ({done, regwen, enrregA, alu_start, busy, instr_ready} !== 6'b100001) begin
            $display("FAIL nop_c1: got %b expected %b",
                     {done, regwen, enrregA, alu_start, busy, instr_ready}, 6'b100001);
            n_fail++;
        end
        @(negedge clock);
        n_checks++;
        if ({done, regwen, busy} !== 3'b000) begin
            $display("FAIL nop_c2: got %b expected %b", {done, regwen, busy}, 3'b000);
            n_fail++;
        end
    endtask

    task automatic test_load;
        issue(mk(2'b01, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00), 64'hA5A5_0000_1234_5678);
        n_checks++;
        if ({regwen, done, busy, instr_ready} !== 4'b1110) begin
            $display("FAIL load_ctrl: got %b expected %b",
                     {regwen, done, busy, instr_ready}, 4'b1110);
            n_fail++;
        end
        n_checks++;
        if ({selwreg, endwreg} !== {4'd3, 2'b00}) begin
            $display("FAIL load_sel: got %h/%h expected 3/0", selwreg, endwreg);
            n_fail++;
        end
        n_checks++;
        if (wdata !== 64'hA5A5_0000_1234_5678) begin
            $display("FAIL load_wdata: got %h expected %h", wdata, 64'hA5A5_0000_1234_5678);
            n_fail++;
        end
        @(negedge clock);
        n_checks++;
        if ({regwen, done, busy, instr_ready} !== 4'b0001) begin
            $display("FAIL load_after: got %b expected %b",
                     {regwen, done, busy, instr_ready}, 4'b0001);
            n_fail++;
        end
    endtask

    task automatic test_move;
        bank_outA = 64'h1111_2222_3333_4444;
        issue(mk(2'b11, 4'd7, 4'd3, 4'd0, 1'b0, 1'b0, 2'b11, 2'b00), 64'h0);
        n_checks++;
        if ({enrregA, enrregB, regwen, busy, seloutA, cnstA} !== {4'b1001, 4'd3, 1'b0}) begin
            $display("FAIL move_read: got %b expected %b",
                     {enrregA, enrregB, regwen, busy, seloutA, cnstA}, {4'b1001, 4'd3, 1'b0});
            n_fail++;
        end
        @(negedge clock);
        n_checks++;
        if ({regwen, done, enrregA} !== 3'b110) begin
            $display("FAIL move_write: got %b expected %b", {regwen, done, enrregA}, 3'b110);
            n_fail++;
        end
        n_checks++;
        if ({selwreg, endwreg} !== {4'd7, 2'b11}) begin
            $display("FAIL move_sel: got %h/%h expected 7/3", selwreg, endwreg);
            n_fail++;
        end
        n_checks++;
        if (wdata !== 64'h1111_2222_3333_4444) begin
            $display("FAIL move_wdata: got %h expected %h", wdata, 64'h1111_2222_3333_4444);
            n_fail++;
        end
        @(negedge clock);
        n_checks++;
        if ({regwen, done, busy} !== 3'b000) begin
            $display("FAIL move_after: got %b expected %b", {regwen, done, busy}, 3'b000);
            n_fail++;
        end
    endtask

    task automatic test_alu;
        int starts;
        issue(mk(2'b10, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 2'b01, 2'b01), 64'h0);
        n_checks++;
        if ({enrregA, enrregB, alu_start, regwen, seloutA, seloutB, cnstA, cnstB}
            !== {4'b1100, 4'd1, 4'd2, 2'b10}) begin
            $display("FAIL alu_read: got %b expected %b",
                     {enrregA, enrregB, alu_start, regwen, seloutA, seloutB, cnstA, cnstB},
                     {4'b1100, 4'd1, 4'd2, 2'b10});
            n_fail++;
        end
        @(negedge clock);
        starts = alu_start ? 1 : 0;
        n_checks++;
        if ({alu_start, alu_op, enrregA} !== 4'b1010) begin
            $display("FAIL alu_issue: got %b expected %b", {alu_start, alu_op, enrregA}, 4'b1010);
            n_fail++;
        end
        for (int c = 3; c <= 2 + AluDelay; c++) begin
            @(negedge clock);
            if (alu_start) starts++;
            n_checks++;
            if ({regwen, busy, alu_op} !== 4'b0101) begin
                $display("FAIL alu_wait c%0d: got %b expected %b", c,
                         {regwen, busy, alu_op}, 4'b0101);
                n_fail++;
            end
        end
        alu_done   = 1'b1;
        alu_result = 64'hDEAD_BEEF_0000_0001;
        @(negedge clock);
        if (alu_start) starts++;
        alu_done   = 1'b0;
        alu_result = '0;
        n_checks++;
        if ({regwen, done, selwreg, endwreg} !== {2'b11, 4'd5, 2'b01}) begin
            $display("FAIL alu_write: got %b expected %b",
                     {regwen, done, selwreg, endwreg}, {2'b11, 4'd5, 2'b01});
            n_fail++;
        end
        n_checks++;
        if (wdata !== 64'hDEAD_BEEF_0000_0001) begin
            $display("FAIL alu_wdata: got %h expected %h", wdata, 64'hDEAD_BEEF_0000_0001);
            n_fail++;
        end
        @(negedge clock);
        n_checks++;
        if (starts !== 1) begin
            $display("FAIL alu_start_count: got %0d expected 1", starts);
            n_fail++;
        end
        n_checks++;
        if ({regwen, busy, wdata} !== {2'b00, 64'hDEAD_BEEF_0000_0001}) begin
            $display("FAIL alu_after: got %b/%h expected 00/%h", {regwen, busy}, wdata,
                     64'hDEAD_BEEF_0000_0001);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] q [3];
        logic [3:0]  wr_dst [2];
        logic        rdy;
        int          idx = 0;
        int          nwr = 0;
        int          ndone = 0;
        q[0] = mk(2'b00, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        q[1] = mk(2'b01, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 2'b00);
        q[2] = mk(2'b11, 4'd9, 4'd4, 4'd0, 1'b0, 1'b0, 2'b10, 2'b00);
        wr_dst[0] = '0;
        wr_dst[1] = '0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 3) begin
                instr_valid = 1'b1;
                instr       = q[idx];
                ld_data     = 64'h0BAD_0000_0000_0000 + 64'(idx);
            end else begin
                instr_valid = 1'b0;
            end
            rdy = instr_ready;
            @(posedge clock);
            if (rdy && instr_valid) idx++;
            @(negedge clock);
            n_checks++;
            if (instr_ready !== !busy) begin
                $display("FAIL b2b_ready c%0d: got ready %b busy %b", c, instr_ready, busy);
                n_fail++;
            end
            if (regwen) begin
                if (nwr < 2) wr_dst[nwr] = selwreg;
                nwr++;
            end
            if (done) ndone++;
        end
        instr_valid = 1'b0;
        instr       = '0;
        ld_data     = '0;
        n_checks++;
        if (idx !== 3 || ndone !== 3) begin
            $display("FAIL b2b_accepts: got %0d accepts %0d dones expected 3/3", idx, ndone);
            n_fail++;
        end
        n_checks++;
        if (nwr !== 2 || wr_dst[0] !== 4'd2 || wr_dst[1] !== 4'd9) begin
            $display("FAIL b2b_writes: got %0d writes dst %0d,%0d expected 2 writes dst 2,9",
                     nwr, wr_dst[0], wr_dst[1]);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_op;
        issue(mk(2'b10, 4'd6, 4'd1, 4'd2, 1'b1, 1'b1, 2'b10, 2'b11), 64'h0);
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({busy, alu_op} !== 3'b111) begin
            $display("FAIL rst_mid_wait: got %b expected %b", {busy, alu_op}, 3'b111);
            n_fail++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        alu_done   = 1'b1;
        alu_result = 64'hFFFF_0000_FFFF_0000;
        n_checks++;
        if ({regwen, enrregA, enrregB, cnstA, cnstB, alu_start, done, err_timeout, busy,
             instr_ready} !== 10'b0000000001) begin
            $display("FAIL rst_mid_ctrl: got %b expected %b", {regwen, enrregA, enrregB, cnstA,
                     cnstB, alu_start, done, err_timeout, busy, instr_ready}, 10'b0000000001);
            n_fail++;
        end
        n_checks++;
        if ({selwreg, endwreg, seloutA, seloutB, alu_op} !== 16'h0000 || wdata !== 64'h0) begin
            $display("FAIL rst_mid_sel: got %h/%h expected 0/0",
                     {selwreg, endwreg, seloutA, seloutB, alu_op}, wdata);
            n_fail++;
        end
        @(negedge clock);
        alu_done   = 1'b0;
        alu_result = '0;
        n_checks++;
        if ({regwen, done, busy, instr_ready} !== 4'b0001 || wdata !== 64'h0) begin
            $display("FAIL rst_late_done: got %b/%h expected 0001/0",
                     {regwen, done, busy, instr_ready}, wdata);
            n_fail++;
        end
    endtask

    task automatic test_timeout;
        issue(mk(2'b10, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0, 2'b00, 2'b10), 64'h0);
        @(negedge clock);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clock);
            n_checks++;
            if ({busy, done, err_timeout, regwen} !== 4'b1000) begin
                $display("FAIL to_wait c%0d: got %b expected %b", c,
                         {busy, done, err_timeout, regwen}, 4'b1000);
                n_fail++;
            end
        end
`ifdef REGBANK_SEQ_TIMEOUT_EN
        @(negedge clock);
        n_checks++;
        if ({busy, done, err_timeout, regwen} !== 4'b0110) begin
            $display("FAIL to_fire: got %b expected %b", {busy, done, err_timeout, regwen}, 4'b0110);
            n_fail++;
        end
        @(negedge clock);
        n_checks++;
        if ({busy, done, err_timeout, regwen} !== 4'b0010) begin
            $display("FAIL to_sticky: got %b expected %b",
                     {busy, done, err_timeout, regwen}, 4'b0010);
            n_fail++;
        end
`else
        for (int c = 7; c < 30; c++) begin
            @(negedge clock);
            n_checks++;
            if ({busy, done, err_timeout, regwen} !== 4'b1000) begin
                $display("FAIL to_hold c%0d: got %b expected %b", c,
                         {busy, done, err_timeout, regwen}, 4'b1000);
                n_fail++;
            end
        end
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({busy, err_timeout, instr_ready} !== 3'b001) begin
            $display("FAIL to_clear: got %b expected %b", {busy, err_timeout, instr_ready}, 3'b001);
            n_fail++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_nop();
        test_load();
        test_move();
        test_alu();
        test_back_to_back();
        test_reset_mid_op();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
